// File: rtl/calc_if.sv
// calc_if: opcode/operand byte stream in, result/err stream out, plus busy status.
interface calc_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        res_valid;
    logic        res_ready;
    logic        err;
    logic        busy;
    modport master (output in_data, in_valid, res_ready, input in_ready, result, res_valid, err, busy);
    modport slave (input in_data, in_valid, res_ready, output in_ready, result, res_valid, err, busy);
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: takes opcode, A, B bytes and returns ADD/SUB in one cycle,
// MUL (shift-add) and DIV (restoring) in eight iterations.
module calc_sequencer #(
    parameter logic [15:0] DIVZ_RESULT = 16'hFFFF
) (
    input logic   clk,
    input logic   rst_n,
    input logic   ena,
    calc_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d, result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic        ill_q, ill_d, err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        accept, divz, done, ge;
    logic [8:0]  msum, rtrial, rsub;
    logic [15:0] step, res_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            ill_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            op_q     <= op_d;
            ill_q    <= ill_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = state_q == IDLE ? GET_A : state_q == GET_A ? GET_B : EXEC;
        if (state_q == EXEC && done)
            state_d = DONE;
        if (state_q == DONE && bus.res_ready)
            state_d = IDLE;
    end

    always_comb begin
        bus.in_ready  = rst_n & ena & (state_q == IDLE || state_q == GET_A || state_q == GET_B);
        bus.busy      = state_q != IDLE;
        bus.res_valid = state_q == DONE;
        bus.result    = result_q;
        bus.err       = err_q;
    end

    // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        accept   = bus.in_valid & bus.in_ready;
        divz     = op_q == 2'd3 && b_q == 8'h00;
        done     = ill_q | ~op_q[1] | divz | (cnt_q == 3'd7);
        msum     = {1'b0, acc_q[15:8]} + {1'b0, acc_q[0] ? a_q : 8'h00};
        rtrial   = {acc_q[15:8], acc_q[7]};
        ge       = rtrial >= {1'b0, b_q};
        rsub     = rtrial - {1'b0, b_q};
        step     = op_q[0] ? {ge ? rsub[7:0] : rtrial[7:0], acc_q[6:0], ge} : {msum, acc_q[7:1]};
        res_fin  = ill_q ? 16'h0000 : op_q == 2'd0 ? {7'b0, {1'b0, a_q} + {1'b0, b_q}} :
                   op_q == 2'd1 ? {8'h00, a_q} - {8'h00, b_q} : divz ? DIVZ_RESULT : step;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        op_d     = op_q;
        ill_d    = ill_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (accept && state_q == IDLE) begin
            op_d  = bus.in_data[1:0];
            ill_d = |bus.in_data[7:2];
        end
        if (accept && state_q == GET_A)
            a_d = bus.in_data;
        if (accept && state_q == GET_B) begin
            b_d   = bus.in_data;
            cnt_d = 3'd0;
            acc_d = {8'h00, op_q[0] ? a_q : bus.in_data};
        end
        if (state_q == EXEC) begin
            acc_d = step;
            cnt_d = done ? cnt_q : cnt_q + 3'd1;
            if (done) begin
                result_d = res_fin;
                err_d    = ill_q | divz;
            end
        end
    end
endmodule
